// File: rtl/seq_lock_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_lock_param
// Purpose  : Parametrised sequential code lock with press edge detection,
//            failed-attempt counting, timed lockout and 7-segment status.
// Revision : 1.0 - initial release
// ============================================================================
module seq_lock_param #(
  parameter int              DW       = 4,
  parameter int              N        = 4,
  parameter logic [N*DW-1:0] SEQ      = 16'h5379,
  parameter int              MAX_TENT = 3,
  parameter int              LOCK_CYC = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] numero,
  input  logic          insere,
  output logic          led,
  output logic          erro,
  output logic          bloq,
  output logic [6:0]    display
);

  localparam int FW = (MAX_TENT > 1) ? $clog2(MAX_TENT) : 1;
  localparam int TW = $clog2(LOCK_CYC + 1);

  localparam logic [3:0]    c_LAST_IDX  = 4'(N - 1);
  localparam logic [FW-1:0] c_FAIL_LAST = FW'(MAX_TENT - 1);
  localparam logic [TW-1:0] c_LOCK      = TW'(LOCK_CYC);
  localparam logic [TW-1:0] c_TIMER_ONE = TW'(1);

  typedef enum logic [1:0] {
    ENTRADA  = 2'd0,
    ABERTO   = 2'd1,
    ERRO     = 2'd2,
    BLOQUEIO = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_idx, w_idx_nxt;
  logic          r_mismatch, w_mismatch_nxt;
  logic [FW-1:0] r_fail, w_fail_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_insere_d;

  logic          w_accept;
  logic [DW-1:0] w_exp;
  logic          w_mis_now;

  assign w_accept  = insere & ~r_insere_d;
  assign w_mis_now = r_mismatch | (numero != w_exp);

  // Secret digit currently expected; first digit lives in the MS bits.
  always_comb begin
    w_exp = '0;
    for (int i = 0; i < N; i++) begin
      if (r_idx == 4'(i)) w_exp = SEQ[(N-1-i)*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ENTRADA;
      r_idx      <= '0;
      r_mismatch <= 1'b0;
      r_fail     <= '0;
      r_timer    <= '0;
      r_insere_d <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_mismatch <= w_mismatch_nxt;
      r_fail     <= w_fail_nxt;
      r_timer    <= w_timer_nxt;
      r_insere_d <= insere;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_mismatch_nxt = r_mismatch;
    w_fail_nxt     = r_fail;
    w_timer_nxt    = r_timer;
    case (r_state)
      ENTRADA: begin
        if (w_accept) begin
          if (r_idx != c_LAST_IDX) begin
            w_idx_nxt      = r_idx + 4'd1;
            w_mismatch_nxt = w_mis_now;
          end else begin
            // Verdict only after the full sequence, so timing never leaks
            // which digit was wrong.
            w_idx_nxt      = '0;
            w_mismatch_nxt = 1'b0;
            if (!w_mis_now) begin
              w_state_nxt = ABERTO;
              w_fail_nxt  = '0;
            end else if (r_fail == c_FAIL_LAST) begin
              w_state_nxt = BLOQUEIO;
              w_timer_nxt = c_LOCK;
              w_fail_nxt  = '0;
            end else begin
              w_state_nxt = ERRO;
              w_fail_nxt  = r_fail + FW'(1);
            end
          end
        end
      end
      ABERTO, ERRO: begin
        if (w_accept) w_state_nxt = ENTRADA;
      end
      BLOQUEIO: begin
        if (r_timer <= c_TIMER_ONE) begin
          w_state_nxt = ENTRADA;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - c_TIMER_ONE;
        end
      end
      default: w_state_nxt = ENTRADA;
    endcase
  end

  always_comb begin
    led     = (r_state == ABERTO);
    erro    = (r_state == ERRO);
    bloq    = (r_state == BLOQUEIO);
    display = 7'h3F;
    case (r_state)
      ENTRADA: begin
        case (r_idx)
          4'd0:    display = 7'h3F;
          4'd1:    display = 7'h06;
          4'd2:    display = 7'h5B;
          4'd3:    display = 7'h4F;
          4'd4:    display = 7'h66;
          4'd5:    display = 7'h6D;
          4'd6:    display = 7'h7D;
          4'd7:    display = 7'h07;
          4'd8:    display = 7'h7F;
          default: display = 7'h3F;
        endcase
      end
      ABERTO:   display = 7'h77;
      ERRO:     display = 7'h79;
      BLOQUEIO: display = 7'h38;
      default:  display = 7'h3F;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_lock_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_lock_param
// Purpose  : Scoreboard bench for seq_lock_param (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_lock_param;

  logic       clk;
  logic       reset;
  logic [3:0] numero;
  logic       insere;
  logic       led, erro, bloq;
  logic [6:0] display;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } exp_t;
  exp_t sbq[$];

  // Reference model: 0=ENTRADA 1=ABERTO 2=ERRO 3=BLOQUEIO
  int m_state, m_idx, m_mis, m_fail;
  int secret[4] = '{5, 3, 7, 9};
  logic [6:0] seg[9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                         7'h6D, 7'h7D, 7'h07, 7'h7F};

  seq_lock_param #(
    .DW(4), .N(4), .SEQ(16'h5379), .MAX_TENT(3), .LOCK_CYC(16)
  ) dut (
    .clk(clk), .reset(reset), .numero(numero), .insere(insere),
    .led(led), .erro(erro), .bloq(bloq), .display(display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] m_out();
    logic [6:0] d;
    case (m_state)
      1:       d = 7'h77;
      2:       d = 7'h79;
      3:       d = 7'h38;
      default: d = seg[m_idx];
    endcase
    return {m_state == 1, m_state == 2, m_state == 3, d};
  endfunction

  task automatic m_reset();
    m_state = 0; m_idx = 0; m_mis = 0; m_fail = 0;
  endtask

  task automatic m_press(input int d);
    case (m_state)
      0: begin
        if (d != secret[m_idx]) m_mis = 1;
        if (m_idx < 3) m_idx++;
        else begin
          if (m_mis == 0) begin m_state = 1; m_fail = 0; end
          else if (m_fail + 1 == 3) begin m_state = 3; m_fail = 0; end
          else begin m_state = 2; m_fail++; end
          m_idx = 0; m_mis = 0;
        end
      end
      1, 2: m_state = 0;
      default: ;
    endcase
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk(e.tag, {22'd0, led, erro, bloq, display}, {22'd0, e.exp});
    end
  endtask

  // One press: insere high for one cycle, returns at the following negedge with insere low.
  task automatic press(input int d, input string tag);
    exp_t e;
    @(negedge clk);
    numero = 4'(d);
    insere = 1'b1;
    m_press(d);
    e.tag = tag;
    e.exp = m_out();
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
    @(negedge clk);
    insere = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    insere = 1'b0;
    reset  = 1'b0;
    m_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset  = 1'b0;
    insere = 1'b0;
    numero = 4'd0;
    m_reset();
    #1;
    chk("reset_out", {22'd0, led, erro, bloq, display}, {22'd0, 3'b000, 7'h3F});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 1: correct code, then leave ABERTO
    press(5, "t1_d0"); press(3, "t1_d1"); press(7, "t1_d2"); press(9, "t1_open");
    chk("t1_led", {31'd0, led}, 32'd1);
    press(1, "t1_close");

    // 2: wrong third digit; verdict only after the fourth
    press(5, "t2_d0"); press(3, "t2_d1"); press(2, "t2_d2_noearly"); press(9, "t2_err");
    chk("t2_disp_err", {25'd0, display}, {25'd0, 7'h79});
    press(4, "t2_exit");
    @(posedge clk); #1;
    chk("t2_not_counted", {25'd0, display}, {25'd0, 7'h3F});

    // 3: lockout after three failures, lasting exactly 16 cycles
    do_reset();
    for (int a = 0; a < 3; a++) begin
      for (int k = 0; k < 4; k++) press(1, $sformatf("t3_a%0d_p%0d", a, k));
      if (a < 2) press(1, $sformatf("t3_a%0d_exit", a));
    end
    chk("t3_bloq", {31'd0, bloq}, 32'd1);
    for (int k = 1; k <= 16; k++) begin
      insere = (k % 3 == 0);
      numero = 4'd5;
      @(posedge clk); #1;
      chk($sformatf("t3_lock_c%0d", k), {22'd0, led, erro, bloq, display},
          (k < 16) ? {22'd0, 3'b001, 7'h38} : {22'd0, 3'b000, 7'h3F});
      @(negedge clk);
    end
    insere = 1'b0;
    m_reset();

    // 4: held press counts once
    @(negedge clk);
    numero = 4'd5;
    insere = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t4_hold%0d", k), {25'd0, display}, {25'd0, 7'h06});
      @(negedge clk);
    end
    insere = 1'b0;
    m_press(5);
    press(3, "t4_second"); press(7, "t4_d2"); press(9, "t4_open"); press(0, "t4_close");

    // 5: asynchronous reset mid-entry, then release with insere held high
    press(5, "t5_d0"); press(3, "t5_d1");
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_async", {22'd0, led, erro, bloq, display}, {22'd0, 3'b000, 7'h3F});
    m_reset();
    insere = 1'b1;
    numero = 4'd5;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t5_held%0d", k), {25'd0, display}, {25'd0, 7'h3F});
    end
    @(negedge clk);
    insere = 1'b0;
    press(5, "t5_after");

    // 6: a success clears the failure count
    do_reset();
    for (int k = 0; k < 4; k++) press(2, $sformatf("t6_f1_%0d", k));
    press(0, "t6_f1_exit");
    for (int k = 0; k < 4; k++) press(2, $sformatf("t6_f2_%0d", k));
    press(0, "t6_f2_exit");
    for (int k = 0; k < 4; k++) press(secret[k], $sformatf("t6_ok_%0d", k));
    press(0, "t6_ok_exit");
    for (int a = 0; a < 2; a++) begin
      for (int k = 0; k < 4; k++) press(8, $sformatf("t6_g%0d_%0d", a, k));
      if (a == 0) press(0, "t6_g0_exit");
    end
    chk("t6_final", {29'd0, led, erro, bloq}, {29'd0, 3'b010});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
